// File: rtl/vend_pkg.sv
// Shared vending definitions: coin codes, coin values and dispenser states.
package vend_pkg;

   // Coin code, same encoding as the vending-machine coin input.
   typedef enum logic [1:0] {
      COIN_NONE    = 2'b00,
      COIN_NICKEL  = 2'b01,
      COIN_DIME    = 2'b10,
      COIN_QUARTER = 2'b11
   } coin_e;

   // Coin values in nickel units.
   localparam int NICKEL_VAL  = 1;
   localparam int DIME_VAL    = 2;
   localparam int QUARTER_VAL = 5;

   typedef enum logic [1:0] {
      IDLE,
      SELECT,
      PRESENT,
      DONE
   } disp_state_e;

   // Value of a coin code in nickels; COIN_NONE is worth nothing.
   function automatic int coin_value(input coin_e c);
      case (c)
         COIN_NICKEL:  return NICKEL_VAL;
         COIN_DIME:    return DIME_VAL;
         COIN_QUARTER: return QUARTER_VAL;
         default:      return 0;
      endcase
   endfunction

endpackage

// File: rtl/coin_select.sv
// Greedy coin choice: largest non-empty denomination that fits in remain.
module coin_select
   import vend_pkg::*;
#(
   parameter int CREDIT_W = 5
) (
   input  logic [CREDIT_W-1:0] remain,
   input  logic [2:0]          tube_empty,
   output logic                found,
   output coin_e               coin
);

   // Widened copy so the comparisons work for any CREDIT_W.
   logic [31:0] rem_w;
   assign rem_w = 32'(remain);

   // Quarter beats dime beats nickel; a coin never exceeds remain, so no underflow.
   always_comb begin
      found = 1'b0;
      coin  = COIN_NONE;
      if (rem_w >= 32'(QUARTER_VAL) && !tube_empty[2]) begin
         found = 1'b1;
         coin  = COIN_QUARTER;
      end else if (rem_w >= 32'(DIME_VAL) && !tube_empty[1]) begin
         found = 1'b1;
         coin  = COIN_DIME;
      end else if (rem_w >= 32'(NICKEL_VAL) && !tube_empty[0]) begin
         found = 1'b1;
         coin  = COIN_NICKEL;
      end
   end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out a credit one coin at a time over a valid/ready ejector.
module change_dispenser
   import vend_pkg::*;
#(
   parameter int CREDIT_W = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [CREDIT_W-1:0] credit,
   input  logic [2:0]          tube_empty,
   input  logic                coin_ready,
   output logic                coin_valid,
   output logic [1:0]          coin,
   output logic                busy,
   output logic                done,
   output logic                short,
   output logic [CREDIT_W-1:0] remain
);

   disp_state_e         state_q, state_d;
   logic [CREDIT_W-1:0] remain_q;
   logic                short_q;
   coin_e               coin_q;

   logic                sel_found;
   coin_e               sel_coin;
   logic [CREDIT_W-1:0] remain_after;

   coin_select #(.CREDIT_W(CREDIT_W)) u_sel (
      .remain     (remain_q),
      .tube_empty (tube_empty),
      .found      (sel_found),
      .coin       (sel_coin)
   );

   // Credit left once the presented coin has been taken.
   assign remain_after = remain_q - CREDIT_W'(coin_value(coin_q));

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SELECT;
         SELECT:  state_d = sel_found ? PRESENT : DONE;
         PRESENT: if (coin_ready) state_d = (remain_after == '0) ? DONE : SELECT;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register; reset aborts any payout in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Remain/short/coin registers; tube_empty only matters in SELECT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remain_q <= '0;
         short_q  <= 1'b0;
         coin_q   <= COIN_NONE;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               remain_q <= credit;
               short_q  <= 1'b0;
            end
            SELECT: begin
               if (sel_found) coin_q  <= sel_coin;
               else           short_q <= (remain_q != '0);
            end
            PRESENT: if (coin_ready) remain_q <= remain_after;
            default: ;
         endcase
      end
   end

   assign coin_valid = (state_q == PRESENT);
   assign coin       = coin_valid ? coin_q : COIN_NONE;
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign short      = short_q;
   assign remain     = remain_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: expected coins/results queued at start.
module tb_change_dispenser;
   import vend_pkg::*;

   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [CW-1:0] credit = '0;
   logic [2:0]    tube_empty = '0;
   logic          coin_ready = 1'b0;
   logic          coin_valid, busy, done, short;
   logic [1:0]    coin;
   logic [CW-1:0] remain;

   typedef struct {
      logic sh;
      int   rem;
   } res_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   exp_coins[$];
   res_t exp_res[$];
   int   done_seen = 0;

   always #5 clk = ~clk;

   change_dispenser #(.CREDIT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .credit     (credit),
      .tube_empty (tube_empty),
      .coin_ready (coin_ready),
      .coin_valid (coin_valid),
      .coin       (coin),
      .busy       (busy),
      .done       (done),
      .short      (short),
      .remain     (remain)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Reference greedy payout; queues expected coins and final result.
   task automatic model(input int c, input logic [2:0] t,
                        output int n, output logic sh, output int rem);
      res_t r;
      rem = c;
      n   = 0;
      forever begin
         if (rem >= 5 && !t[2])      begin exp_coins.push_back(3); rem -= 5; end
         else if (rem >= 2 && !t[1]) begin exp_coins.push_back(2); rem -= 2; end
         else if (rem >= 1 && !t[0]) begin exp_coins.push_back(1); rem -= 1; end
         else break;
         n++;
      end
      sh    = (rem != 0);
      r.sh  = sh;
      r.rem = rem;
      exp_res.push_back(r);
   endtask

   // Monitor: compare each transferred coin and each done pulse against the queues.
   always @(negedge clk) begin
      res_t r;
      if (rst_n) begin
         if (!coin_valid) chk("coin_idle", coin, 0);
         else if (coin_ready) begin
            if (exp_coins.size() == 0) chk("coin_unexpected", coin, 0);
            else                       chk("coin", coin, exp_coins.pop_front());
         end
         if (done) begin
            done_seen++;
            if (exp_res.size() == 0) chk("done_unexpected", done, 0);
            else begin
               r = exp_res.pop_front();
               chk("short", short, r.sh);
               chk("remain", remain, r.rem);
            end
         end
      end
   end

   task automatic pulse_start(input int c);
      @(posedge clk); #1;
      start  = 1'b1;
      credit = CW'(c);
      @(posedge clk); #1;
      start  = 1'b0;
   endtask

   // Full payout with coin_ready tied high; checks latency, idle return and held result.
   task automatic payout(input int c, input logic [2:0] t, input string name);
      int n, rem, first_valid, done_t, exp_done;
      logic sh;
      tube_empty = t;
      coin_ready = 1'b1;
      model(c, t, n, sh, rem);
      pulse_start(c);
      first_valid = -1;
      done_t      = -1;
      for (int i = 0; i < 100 && done_t < 0; i++) begin
         @(negedge clk);
         if (i == 0) chk({name, "_busy"}, busy, 1);
         if (coin_valid && first_valid < 0) first_valid = i;
         if (done) done_t = i;
      end
      if (done_t < 0) chk({name, "_timeout"}, done, 1);
      else begin
         exp_done = (n == 0 || sh) ? 2 * n + 1 : 2 * n;
         chk({name, "_done_lat"}, done_t, exp_done);
         if (n > 0) chk({name, "_coin_lat"}, first_valid, 1);
         else       chk({name, "_no_coin"}, first_valid, -1);
         @(negedge clk);
         chk({name, "_idle_busy"}, busy, 0);
         chk({name, "_idle_done"}, done, 0);
         repeat (3) @(negedge clk);
         chk({name, "_hold_short"}, short, sh);
         chk({name, "_hold_remain"}, remain, rem);
         chk({name, "_left"}, exp_coins.size(), 0);
      end
   endtask

   task automatic wait_valid(input string name);
      int k;
      k = 0;
      while (!coin_valid && k < 50) begin @(negedge clk); k++; end
      if (!coin_valid) chk({name, "_valid_timeout"}, coin_valid, 1);
   endtask

   initial begin
      int n, rem, snap;
      logic sh;
      // Reset values, before any clock edge.
      #3;
      chk("rst_valid", coin_valid, 0);
      chk("rst_coin", coin, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_short", short, 0);
      chk("rst_remain", remain, 0);
      @(negedge clk);
      rst_n = 1'b1;

      payout(6,  3'b000, "q_n");
      payout(0,  3'b000, "zero");
      payout(5,  3'b100, "d_d_n");
      payout(6,  3'b001, "short");
      payout(31, 3'b000, "max");
      payout(4,  3'b010, "nickels");

      // Stalled ejector: coin holds, start and tube changes ignored.
      tube_empty = 3'b000;
      coin_ready = 1'b0;
      model(5, 3'b000, n, sh, rem);
      snap = done_seen;
      pulse_start(5);
      wait_valid("stall");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("stall_valid", coin_valid, 1);
         chk("stall_coin", coin, 3);
         @(posedge clk); #1;
         start      = (i == 1);
         credit     = CW'(3);
         tube_empty = (i == 1 || i == 2) ? 3'b111 : 3'b000;
      end
      start      = 1'b0;
      tube_empty = 3'b000;
      coin_ready = 1'b1;
      repeat (8) @(negedge clk);
      chk("stall_one_done", done_seen - snap, 1);
      chk("stall_idle", busy, 0);
      chk("stall_left", exp_coins.size(), 0);

      // Reset while a coin is presented.
      coin_ready = 1'b0;
      model(10, 3'b000, n, sh, rem);
      pulse_start(10);
      wait_valid("abort");
      #2 rst_n = 1'b0;
      #1;
      chk("abort_valid", coin_valid, 0);
      chk("abort_coin", coin, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_short", short, 0);
      chk("abort_remain", remain, 0);
      snap = done_seen;
      repeat (2) @(posedge clk);
      exp_coins.delete();
      exp_res.delete();
      #3 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_no_done", done_seen - snap, 0);
      chk("abort_idle", busy, 0);
      payout(2, 3'b000, "after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL have parameter CREDIT_W, default 5, meaning the width of the credit and remain fields in nickel units.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to pay out credit; sampled only in IDLE.
REQ-006 credit  input  CREDIT_W  change owed, in nickels; sampled with start.
REQ-007 tube_empty  input  3  per-denomination empty flags: [0] nickel, [1] dime, [2] quarter.
REQ-008 coin_ready  input  1  ejector accepts the presented coin this cycle.
REQ-009 coin_valid  output  1  a coin is presented for ejection.
REQ-010 coin  output  2  coin code: 00 none, 01 nickel, 10 dime, 11 quarter (same encoding as the vending-machine coin input).
REQ-011 busy  output  1  payout in progress.
REQ-012 done  output  1  one-cycle payout-complete pulse.
REQ-013 short  output  1  exact change could not be paid.
REQ-014 remain  output  CREDIT_W  credit still owed, in nickels.

Function
REQ-015 Coin values SHALL be: nickel 1, dime 2, quarter 5 (nickel units).
REQ-016 The FSM SHALL have four states: IDLE, SELECT, PRESENT, DONE.
REQ-017 IDLE with start=1 SHALL latch credit into remain and go to SELECT; with start=0, SHALL stay in IDLE.
REQ-018 SELECT SHALL last one cycle. It picks the largest denomination whose value is <= remain and whose tube_empty bit is 0. Quarter takes priority over dime, and dime over nickel.
REQ-019 If SELECT finds a coin, the next state SHALL be PRESENT, with coin set to that code and coin_valid=1.
REQ-020 If SELECT finds no coin, or remain=0, the next state SHALL be DONE, with short=1 when remain!=0.
REQ-021 In PRESENT, coin_valid and coin SHALL hold stable until coin_ready=1; a transfer occurs on the edge where both are high.
REQ-022 On a transfer, remain SHALL decrease by the coin value and coin_valid SHALL drop to 0.
REQ-023 After a transfer, the next state SHALL be DONE if the new remain is 0, otherwise SELECT.
REQ-024 tube_empty SHALL be sampled only in SELECT; changes during PRESENT never withdraw a presented coin.
REQ-025 The minimum cost per coin SHALL be 2 cycles: start edge k -> SELECT in k+1 -> coin_valid in k+2.
REQ-026 In DONE, done SHALL be high for exactly one cycle, followed by IDLE.
REQ-027 short and remain SHALL hold their DONE values until the next accepted start; short SHALL clear on an accepted start.
REQ-028 busy SHALL be 1 in SELECT, PRESENT and DONE, and 0 in IDLE.
REQ-029 start while busy=1 SHALL be ignored, not queued.
REQ-030 coin SHALL read 00 whenever coin_valid=0.
REQ-031 A start with credit=0 SHALL give SELECT then DONE with no coin and short=0.
REQ-032 remain SHALL never underflow (guaranteed by REQ-018).

Reset
REQ-033 While rst_n=0, independent of clk, the block SHALL hold: state IDLE, remain 0, coin_valid 0, coin 00, busy 0, done 0, short 0.
REQ-034 Reset asserted mid-payout SHALL abort the payout with no done pulse; an in-flight coin is withdrawn.
REQ-035 Reset release SHALL be followed by IDLE; the first start is accepted no earlier than the first clk edge after release.

Structure
REQ-036 A shared package vend_pkg SHALL hold the coin code enum (COIN_NONE, COIN_NICKEL, COIN_DIME, COIN_QUARTER), the coin value constants and the dispenser state enum.
REQ-037 The greedy choice SHALL live in one combinational sub-module, coin_select (inputs remain and tube_empty; outputs found and coin code). The FSM, remain register and handshake logic stay in change_dispenser.

Verification
REQ-038 credit=6, no tubes empty, coin_ready tied 1 -> QUARTER then NICKEL; done one cycle after the second transfer; short=0; remain=0.
REQ-039 credit=0 -> done pulse two cycles after the start edge; coin_valid never 1; short=0.
REQ-040 credit=5, tube_empty=100 -> DIME, DIME, NICKEL; short=0.
REQ-041 credit=6, tube_empty=001 -> QUARTER, then done with short=1 and remain=1, both held until the next start.
REQ-042 coin_ready held low for 4 cycles in PRESENT; start pulsed and tube_empty toggled meanwhile -> coin and coin_valid stable, no new payout started, single transfer when coin_ready rises.
REQ-043 rst_n pulled low while a coin is presented for credit=10 -> outputs immediately at reset values, no done pulse; after release, a new start with credit=2 gives a single DIME.
